fp_add4_feeder: RTL and testbench

- Producer/collector for the four-input FP adder tree. Packs a serial valid/ready stream of IEEE-754 single-precision values into groups of four. Drives the tree's four operand buses and captures the tree's sum after its fixed latency.
- Credit-based: the tree has no stall, so issue is gated so every in-flight result has a guaranteed result-FIFO slot.

---
 rtl/fp_add4_feeder.sv | 185 ++++++++++++++++++
 tb/tb_fp_add4_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add4_feeder.sv
// fp_add4_feeder: packs a serial FP32 valid/ready stream into groups of four,
// drives the operand buses of a fixed-latency, non-stalling 4-input adder tree
// and collects the tree sums into a result FIFO. Issue is credit-gated so that
// every in-flight sum is guaranteed a FIFO slot when it emerges.
// Optional build macro FP_FEED_STATS_EN adds groups_issued / short_groups
// counters as extra output ports.
module fp_add4_feeder #(
  parameter int ADD_LAT   = 7,
  parameter int RES_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] tree_a,
  output logic [31:0] tree_b,
  output logic [31:0] tree_c,
  output logic [31:0] tree_d,
  input  logic [31:0] tree_out,
  output logic [31:0] res_data,
  output logic        res_last,
  output logic        res_valid,
  input  logic        res_ready
`ifdef FP_FEED_STATS_EN
  ,
  output logic [31:0] groups_issued,
  output logic [31:0] short_groups
`endif
);

  localparam int TREE_LAT = 2 * ADD_LAT;
  localparam int CW       = $clog2(RES_DEPTH + 1);
  localparam int AW       = $clog2(RES_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RES_DEPTH);

  // Tag travelling alongside a group through the tree pipeline.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  logic [1:0]              cnt;
  logic                    pending;
  logic                    group_last;
  tag_t [TREE_LAT-1:0]     tag_pipe;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           mem_count;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [32:0]             mem [RES_DEPTH];
  logic [CW:0]             in_use;

  logic accept, close, fire, credit_ok;
  logic push, pop, load_out, mem_rd, mem_wr, bypass;

  // Credit counts both sums still inside the tree and sums already queued,
  // so an issued group can never find the FIFO full when it exits.
  assign in_use    = {1'b0, outstanding} + {1'b0, mem_count} + {{CW{1'b0}}, res_valid};
  assign credit_ok = in_use < DEPTH_C;
  assign fire      = pending && credit_ok;
  assign in_ready  = !pending || fire;
  assign accept    = in_valid && in_ready;
  assign close     = accept && ((cnt == 2'd3) || in_last);

  assign push     = tag_pipe[TREE_LAT-1].valid;
  assign pop      = res_valid && res_ready;
  assign load_out = !res_valid || pop;
  assign mem_rd   = load_out && (mem_count != '0);
  assign bypass   = load_out && (mem_count == '0) && push;
  assign mem_wr   = push && !bypass;

  // Slot packing: the tree operand registers double as the packing slots.
  // The tree samples them on the fire edge, so a new slot-0 write on that
  // same edge only becomes visible after the old group has been taken.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      pending    <= 1'b0;
      group_last <= 1'b0;
      tree_a     <= '0;
      tree_b     <= '0;
      tree_c     <= '0;
      tree_d     <= '0;
    end else begin
      if (accept) begin
        case (cnt)
          2'd0:    tree_a <= in_data;
          2'd1:    tree_b <= in_data;
          2'd2:    tree_c <= in_data;
          default: tree_d <= in_data;
        endcase
        if (close) begin
          if (cnt < 2'd1) tree_b <= '0;
          if (cnt < 2'd2) tree_c <= '0;
          if (cnt < 2'd3) tree_d <= '0;
          cnt        <= '0;
          group_last <= in_last;
        end else begin
          cnt <= cnt + 2'd1;
        end
      end
      if (close)     pending <= 1'b1;
      else if (fire) pending <= 1'b0;
    end
  end

  // Tag shift register mirrors the tree latency; outstanding tracks its population.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_pipe    <= '0;
      outstanding <= '0;
    end else begin
      tag_pipe <= {tag_pipe[TREE_LAT-2:0], tag_t'{valid: fire, last: group_last}};
      case ({fire, push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Result FIFO control: registered head plus backing store; an exiting sum
  // goes straight to the head when the store is empty and the head is free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({mem_wr, mem_rd})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
      if (load_out) begin
        if (mem_rd) begin
          {res_last, res_data} <= mem[rd_ptr];
          res_valid            <= 1'b1;
        end else if (bypass) begin
          res_data  <= tree_out;
          res_last  <= tag_pipe[TREE_LAT-1].last;
          res_valid <= 1'b1;
        end else begin
          res_valid <= 1'b0;
        end
      end
    end
  end

  // Backing store write port.
  // NOTE: storage is not reset; occupancy is defined by the pointers and
  // count, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= {tag_pipe[TREE_LAT-1].last, tree_out};
  end

`ifdef FP_FEED_STATS_EN
  logic group_full;

  // Issue statistics; group_full remembers whether the closing group used all four slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      group_full    <= 1'b0;
      groups_issued <= '0;
      short_groups  <= '0;
    end else begin
      if (close) group_full <= (cnt == 2'd3);
      if (fire) begin
        groups_issued <= groups_issued + 32'd1;
        if (!group_full) short_groups <= short_groups + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_add4_feeder.sv
// Self-checking bench for fp_add4_feeder: table-driven group vectors, hand
// sequences for streaming, backpressure, reset and close-during-fire, and a
// randomized run scored against a grouping/summing reference model.
module tb_fp_add4_feeder;

  localparam int ADD_LAT  = 7;
  localparam int RES_DEPTH = 16;
  localparam int TREE_LAT = 2 * ADD_LAT;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] tree_a, tree_b, tree_c, tree_d;
  logic [31:0] tree_out;
  logic [31:0] res_data;
  logic        res_last;
  logic        res_valid;
  logic        res_ready;
`ifdef FP_FEED_STATS_EN
  logic [31:0] groups_issued;
  logic [31:0] short_groups;
`endif

  always #5 clk = ~clk;

  fp_add4_feeder #(.ADD_LAT(ADD_LAT), .RES_DEPTH(RES_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .tree_a(tree_a), .tree_b(tree_b), .tree_c(tree_c), .tree_d(tree_d),
    .tree_out(tree_out),
    .res_data(res_data), .res_last(res_last), .res_valid(res_valid), .res_ready(res_ready)
`ifdef FP_FEED_STATS_EN
    , .groups_issued(groups_issued), .short_groups(short_groups)
`endif
  );

  // Integer-valued FP32 helpers: all operands are small integers, so sums are exact.
  function automatic logic [31:0] int_to_fp(input int unsigned v);
    int unsigned p;
    int unsigned m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (v[i]) p = i;
    m = (v << (23 - p)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned fp_to_int(input logic [31:0] b);
    int e;
    int unsigned m;
    if (b[30:0] == 31'h0) return 0;
    e = int'(b[30:23]) - 127;
    m = {8'h0, 1'b1, b[22:0]};
    return m >> (23 - e);
  endfunction

  // Adder tree model: fixed-latency pipeline, no stall.
  logic [31:0] tree_pipe [TREE_LAT];
  always @(posedge clk) begin
    tree_pipe[0] <= int_to_fp(fp_to_int(tree_a) + fp_to_int(tree_b) +
                              fp_to_int(tree_c) + fp_to_int(tree_d));
    for (int i = 1; i < TREE_LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
  end
  assign tree_out = tree_pipe[TREE_LAT-1];

  // Reference model: accepted beats grouped by 4 or in_last, expected sums queued.
  typedef struct {
    logic [31:0] sum;
    logic        last;
  } exp_t;

  exp_t        exp_q [$];
  int unsigned grp_sum;
  int          grp_n;
  int          n_pass, n_total;
  int          delivered;
  int          cyc;
  int          pop_cycles [$];
  int          stalls;
  logic        rand_rr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_accept(input logic [31:0] d, input logic lst);
    grp_sum += fp_to_int(d);
    grp_n++;
    if (lst || grp_n == 4) begin
      exp_q.push_back('{sum: int_to_fp(grp_sum), last: lst});
      grp_sum = 0;
      grp_n   = 0;
    end
  endtask

  // One clock: score any result handshake at the negedge, then advance.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got %h with no result expected (cycle %0d)", res_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("res_data", res_data, e.sum);
        check("res_last", {31'h0, res_last}, {31'h0, e.last});
      end
      delivered++;
      pop_cycles.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rand_rr) res_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [31:0] d, input logic lst);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = lst;
    w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
      return;
    end
    model_accept(d, lst);
    stalls += w;
    tick();
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 600) begin
      tick();
      w++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  function automatic logic [31:0] rand_fp();
    return int_to_fp($urandom_range(0, 255));
  endfunction

  typedef struct {
    int                n;
    logic [0:3][31:0]  d;
    logic              lst;
    logic [0:3][31:0]  te;
    logic [31:0]       sum;
    logic              rl;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat, d0, accepted, bad;
    logic stalled;
    logic [31:0] x;

    vecs[0] = '{n: 4, d: {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}, lst: 1'b1,
                te: {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}, sum: 32'h41200000, rl: 1'b1};
    vecs[1] = '{n: 2, d: {32'h3F800000, 32'h40000000, 32'h0, 32'h0}, lst: 1'b1,
                te: {32'h3F800000, 32'h40000000, 32'h0, 32'h0}, sum: 32'h40400000, rl: 1'b1};
    vecs[2] = '{n: 4, d: {32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000}, lst: 1'b0,
                te: {32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000}, sum: 32'h41D00000, rl: 1'b0};
    vecs[3] = '{n: 1, d: {32'h42280000, 32'h0, 32'h0, 32'h0}, lst: 1'b1,
                te: {32'h42280000, 32'h0, 32'h0, 32'h0}, sum: 32'h42280000, rl: 1'b1};
    vecs[4] = '{n: 3, d: {32'h3F800000, 32'h3F800000, 32'h0, 32'h0}, lst: 1'b1,
                te: {32'h3F800000, 32'h3F800000, 32'h0, 32'h0}, sum: 32'h40000000, rl: 1'b1};

    n_pass = 0; n_total = 0; delivered = 0; cyc = 0; stalls = 0;
    grp_sum = 0; grp_n = 0; rand_rr = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_res_valid", {31'h0, res_valid}, 32'h0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_res_last", {31'h0, res_last}, 32'h0);
    check("rst_tree_a", tree_a, 32'h0);
    check("rst_tree_d", tree_d, 32'h0);
    reset = 1'b0;
    tick();
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // Table-driven groups: operand buses at fire, latency, sum and last flag
    res_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vecs[v].n; j++)
        send_beat(vecs[v].d[j], (j == vecs[v].n - 1) ? vecs[v].lst : 1'b0);
      in_valid = 1'b0;
      check($sformatf("v%0d_tree_a", v), tree_a, vecs[v].te[0]);
      check($sformatf("v%0d_tree_b", v), tree_b, vecs[v].te[1]);
      check($sformatf("v%0d_tree_c", v), tree_c, vecs[v].te[2]);
      check($sformatf("v%0d_tree_d", v), tree_d, vecs[v].te[3]);
      lat = 0;
      while (!res_valid && lat < 60) begin
        tick();
        lat++;
      end
      check($sformatf("v%0d_latency", v), lat, 2 * ADD_LAT + 1);
      check($sformatf("v%0d_sum", v), res_data, vecs[v].sum);
      check($sformatf("v%0d_last", v), {31'h0, res_last}, {31'h0, vecs[v].rl});
      drain();
    end

    // Streaming: 64 back-to-back beats, no in_last
    stalls = 0;
    pop_cycles.delete();
    d0 = delivered;
    for (int i = 0; i < 64; i++) send_beat(rand_fp(), 1'b0);
    in_valid = 1'b0;
    check("stream_stalls", stalls, 0);
    drain();
    check("stream_results", delivered - d0, 16);
    bad = 0;
    for (int k = 1; k < pop_cycles.size(); k++)
      if (pop_cycles[k] - pop_cycles[k-1] != 4) bad++;
    check("stream_spacing", bad, 0);

    // Backpressure: credit exhausts after RES_DEPTH issued groups
    res_ready = 1'b0;
    d0 = delivered;
    accepted = 0;
    stalled = 1'b0;
    for (int i = 0; i < 200 && !stalled; i++) begin
      in_valid = 1'b1;
      in_data  = rand_fp();
      in_last  = 1'b0;
      lat = 0;
      while (!in_ready && lat < 30) begin
        tick();
        lat++;
      end
      if (!in_ready) stalled = 1'b1;
      else begin
        model_accept(in_data, 1'b0);
        tick();
        accepted++;
      end
    end
    check("bp_accepted_beats", accepted, (RES_DEPTH + 1) * 4);
    check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    // Close a one-beat group on the very cycle credit frees and the pending group fires
    x = int_to_fp(77);
    in_data = x;
    in_last = 1'b1;
    res_ready = 1'b1;
    send_beat(x, 1'b1);
    for (int g = 0; g < 40 - (RES_DEPTH + 1); g++)
      for (int j = 0; j < 4; j++) send_beat(rand_fp(), 1'b0);
    in_valid = 1'b0;
    drain();
    check("bp_delivered", delivered - d0, 41);

    // Reset mid-flight: in-flight work discarded
    res_ready = 1'b0;
    for (int i = 0; i < 12; i++) send_beat(rand_fp(), (i % 4) == 3);
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    grp_sum = 0;
    grp_n = 0;
    check("mid_rst_res_valid", {31'h0, res_valid}, 32'h0);
    reset = 1'b0;
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    res_ready = 1'b1;
    d0 = delivered;
    repeat (40) tick();
    check("post_rst_no_stale", delivered - d0, 0);
    for (int j = 0; j < 4; j++) send_beat(rand_fp(), j == 3);
    in_valid = 1'b0;
    drain();
    check("post_rst_one_result", delivered - d0, 1);

    // Randomized groups, gaps and consumer backpressure
    rand_rr = 1'b1;
    for (int g = 0; g < 40; g++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        send_beat(rand_fp(), (j == n - 1) && (n < 4 || $urandom_range(0, 1) == 1));
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          tick();
        end
      end
    end
    in_valid = 1'b0;
    drain();
    rand_rr = 1'b0;
    res_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
